// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
// Pure declarations: no logic, no latency, no flow control.
package pwm_pkg;
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;
endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: active duty register plus registered compare against the shared counter.
// Latency: one cycle from cnt to pwm; no backpressure, output is free-running.
module pwm_cmp_ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] cnt,
    input  logic             apply,
    input  logic [WIDTH-1:0] duty_pend,
    output logic             pwm
);
    logic [WIDTH-1:0] duty_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            if (apply) begin
                duty_act <= duty_pend;
            end
            pwm <= enable & (duty_act > cnt);
        end
    end
endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared edge/center-aligned counter and double-buffered period/duty.
// Latency: outputs registered one cycle after cnt; no backpressure, loads apply at period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      mode_in,
    input  logic [WIDTH-1:0]          period_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      load,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic                      pending
);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0]          cnt, cnt_nxt;
    dir_t                      dir, dir_nxt;
    logic [WIDTH-1:0]          period_act, period_pend;
    logic                      mode_act, mode_pend;
    logic [CHANNELS*WIDTH-1:0] duty_pend;
    logic                      pend_q;
    logic                      boundary;
    logic                      apply;

    // Center mode with P==1 turns around at cnt==1 while still counting up.
    always_comb begin
        boundary = 1'b0;
        if (!enable) begin
            boundary = 1'b1;
        end else if (mode_act == MODE_EDGE) begin
            boundary = (cnt == period_act);
        end else begin
            boundary = (period_act == ZERO) ||
                       ((cnt == ONE) && ((dir == DIR_DOWN) || (period_act == ONE)));
        end
    end

    assign apply = boundary & pend_q;

    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (boundary) begin
            cnt_nxt = ZERO;
            dir_nxt = DIR_UP;
        end else if (mode_act == MODE_EDGE) begin
            cnt_nxt = cnt + ONE;
        end else if (dir == DIR_UP) begin
            if (cnt == period_act) begin
                cnt_nxt = cnt - ONE;
                dir_nxt = DIR_DOWN;
            end else begin
                cnt_nxt = cnt + ONE;
            end
        end else begin
            cnt_nxt = cnt - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= ZERO;
            dir          <= DIR_UP;
            period_act   <= '1;
            mode_act     <= MODE_EDGE;
            period_pend  <= '1;
            mode_pend    <= MODE_EDGE;
            duty_pend    <= '0;
            pend_q       <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            dir          <= dir_nxt;
            period_start <= enable & (cnt == ZERO) & (dir == DIR_UP);
            if (apply) begin
                period_act <= period_pend;
                mode_act   <= mode_pend;
            end
            // A load coinciding with a boundary stays pending for the next one.
            if (load) begin
                period_pend <= period_in;
                mode_pend   <= mode_in;
                duty_pend   <= duty_in;
                pend_q      <= 1'b1;
            end else if (apply) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign pending = pend_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_cmp_ch #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .enable   (enable),
            .cnt      (cnt),
            .apply    (apply),
            .duty_pend(duty_pend[i*WIDTH +: WIDTH]),
            .pwm      (pwm_out[i])
        );
    end
endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a period/phase reference model predicts every output cycle.
module tb_pwm_multi;
    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            mode_in;
    logic [W-1:0]    period_in;
    logic [CH*W-1:0] duty_in;
    logic            load;
    logic [CH-1:0]   pwm_out;
    logic            period_start;
    logic            pending;

    always #5 clk = ~clk;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode_in     (mode_in),
        .period_in   (period_in),
        .duty_in     (duty_in),
        .load        (load),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .pending     (pending)
    );

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          ps;
        logic          pend;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: position within the period plus active/pending configuration.
    int phase;
    int p_act, p_pend;
    bit m_act, m_pend;
    int d_act[CH];
    int d_pend[CH];
    bit pflag;

    function automatic int plen(bit m, int p);
        if (!m) return p + 1;
        return (p == 0) ? 1 : 2 * p;
    endfunction

    function automatic int cnt_of(bit m, int p, int ph);
        if (!m) return ph;
        return (ph <= p) ? ph : 2 * p - ph;
    endfunction

    task automatic model_reset();
        phase  = 0;
        p_act  = 255;
        p_pend = 255;
        m_act  = 1'b0;
        m_pend = 1'b0;
        pflag  = 1'b0;
        for (int i = 0; i < CH; i++) begin
            d_act[i]  = 0;
            d_pend[i] = 0;
        end
    endtask

    always @(posedge clk) begin : model
        exp_t e;
        int   c;
        bit   bnd;
        cyc++;
        e = '0;
        if (rst) begin
            model_reset();
        end else begin
            c = cnt_of(m_act, p_act, phase);
            for (int i = 0; i < CH; i++) e.pwm[i] = enable && (d_act[i] > c);
            e.ps = enable && (phase == 0);
            bnd  = !enable || (phase == plen(m_act, p_act) - 1);
            if (bnd && pflag) begin
                p_act = p_pend;
                m_act = m_pend;
                for (int i = 0; i < CH; i++) d_act[i] = d_pend[i];
            end
            phase = bnd ? 0 : phase + 1;
            if (load) begin
                p_pend = int'(period_in);
                m_pend = mode_in;
                for (int i = 0; i < CH; i++) d_pend[i] = int'(duty_in[i*W +: W]);
                pflag = 1'b1;
            end else if (bnd) begin
                pflag = 1'b0;
            end
            e.pend = pflag;
        end
        sbq.push_back(e);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("pwm_out", 32'(pwm_out), 32'(e.pwm));
            check("period_start", 32'(period_start), 32'(e.ps));
            check("pending", 32'(pending), 32'(e.pend));
        end
    end

    task automatic do_load(input bit m, input logic [W-1:0] p, input logic [CH*W-1:0] d);
        mode_in   = m;
        period_in = p;
        duty_in   = d;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int target);
        int n;
        n = 0;
        while (phase != target && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (phase != target) begin
            errors++;
            $display("FAIL wait_phase got=%0d expected=%0d", phase, target);
        end
    endtask

    logic [CH*W-1:0] rd;

    initial begin
        model_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        mode_in   = 1'b0;
        period_in = '0;
        duty_in   = '0;
        load      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Edge mode P=9, duties {0,3,10,255}.
        do_load(1'b0, 8'd9, {8'd255, 8'd10, 8'd3, 8'd0});
        enable = 1'b1;
        repeat (30) @(negedge clk);

        // Mid-period duty change 2 -> 5.
        do_load(1'b0, 8'd9, {4{8'd2}});
        repeat (14) @(negedge clk);
        do_load(1'b0, 8'd9, {4{8'd5}});
        repeat (25) @(negedge clk);

        // Load exactly on the cnt==P cycle with nothing pending.
        wait_phase(9);
        do_load(1'b0, 8'd9, {8'd1, 8'd7, 8'd9, 8'd4});
        repeat (25) @(negedge clk);

        // Center mode P=4 duty 2, then P=1 and P=0 corner cases.
        do_load(1'b1, 8'd4, {8'd2, 8'd4, 8'd5, 8'd1});
        repeat (30) @(negedge clk);
        do_load(1'b1, 8'd1, {8'd0, 8'd1, 8'd2, 8'd1});
        repeat (10) @(negedge clk);
        do_load(1'b1, 8'd0, {8'd0, 8'd1, 8'd2, 8'd0});
        repeat (10) @(negedge clk);

        // Disable mid-period, load P=3, re-enable.
        do_load(1'b0, 8'd6, {8'd1, 8'd2, 8'd3, 8'd7});
        repeat (4) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        do_load(1'b0, 8'd3, {8'd0, 8'd1, 8'd2, 8'd4});
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (12) @(negedge clk);

        // Reset mid center-mode period with a load still pending.
        do_load(1'b1, 8'd6, {4{8'd3}});
        repeat (5) @(negedge clk);
        do_load(1'b0, 8'd2, {4{8'd2}});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (270) @(negedge clk);

        // Randomized traffic.
        repeat (3000) begin
            enable = ($urandom_range(0, 19) != 0);
            rst    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 14) == 0) begin
                for (int i = 0; i < CH; i++)
                    rd[i*W +: W] = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 14));
                case ($urandom_range(0, 9))
                    0:       period_in = 8'd0;
                    1:       period_in = 8'd1;
                    2:       period_in = 8'($urandom_range(20, 40));
                    default: period_in = 8'($urandom_range(2, 12));
                endcase
                mode_in = 1'($urandom_range(0, 1));
                duty_in = rd;
                load    = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        rst    = 1'b0;
        load   = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel PWM generator: CHANNELS outputs share one period counter of WIDTH bits.
- Two modes: edge-aligned (sawtooth) and center-aligned (triangle).
- Period and duty values are double-buffered and take effect only at period boundaries, so no glitches occur.
- Drives LED/motor/audio outputs from a register interface or a sample source in the FPGA top level.

Parameters:
- WIDTH, 8, counter/duty/period bit width (2..16).
- CHANNELS, 4, number of independent PWM outputs (1..16).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run counter; low holds counter idle and forces outputs low.
- mode_in  in  1  0 = edge-aligned, 1 = center-aligned.
- period_in  in  WIDTH  top count P.
- duty_in  in  CHANNELS*WIDTH  per-channel duty; channel i is bits [i*WIDTH +: WIDTH].
- load  in  1  one-cycle strobe; captures mode_in, period_in and duty_in into pending registers.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_start  out  1  registered one-cycle pulse aligned with the first output cycle of each period.
- pending  out  1  high while loaded values are waiting for a boundary.

Behaviour:
- Reset values:
  - cnt=0, dir=up.
  - Active registers: period=all ones, mode=0, duty=0.
  - pending=0, pwm_out=0, period_start=0.
- Edge mode:
  - cnt sequence is 0,1,...,P,0; one period is P+1 cycles.
  - The boundary occurs in the cycle where cnt==P.
- Center mode:
  - cnt sequence is 0,1,...,P (dir flips to down), P-1,...,1, then 0 (dir flips to up); one period is 2P cycles.
  - The boundary occurs in the cycle where cnt==1 and dir=down, i.e. next cnt is 0.
  - P=0 in center mode: cnt stays at 0, period is 1 cycle, boundary every cycle.
  - P=1 in center mode: sequence is 0,1,0,1; the boundary is cnt==1.
- Compare: pwm_out[i] <= enable_q & (duty_active[i] > cnt). One-cycle latency from cnt to pin.
  - duty=0 gives constant low.
  - duty>P gives constant high (edge) or high for the whole period (center).
  - Edge-mode high time = min(duty,P+1) cycles.
  - Center-mode high time = 2*duty-1 cycles for 1<=duty<=P, centred on cnt=0.
- period_start <= enable_q & (cnt==0 & dir==up). It is coincident with the first pwm_out cycle of the period.
- Double buffering:
  - load sets the pending registers and raises pending.
  - At a boundary with pending=1, active<=pending values, pending<=0, and cnt restarts at 0 with dir=up.
- Simultaneous events:
  - load in the same cycle as a boundary: the boundary consumes the previously pending values (if any). The new load stays pending for the next boundary.
  - Back-to-back loads: the last one wins.
- enable low:
  - cnt<=0, dir<=up, pwm_out<=0, period_start<=0.
  - Any pending value is applied immediately (every cycle counts as a boundary).
- enable rising: the first period starts cleanly at cnt=0, with no partial period.
- Mode change applies only at a boundary and restarts the counter at 0, up.
- Active P is reduced below current cnt: this cannot happen, because changes apply only at a boundary.
- rst asserted mid-period: all state returns to reset values on the next edge. Pending loads are discarded.
- Arithmetic: cnt is WIDTH bits, with explicit wrap control only (no natural overflow reliance). The compare is unsigned.

Decomposition:
- Shared package pwm_pkg:
  - localparams MODE_EDGE=1'b0, MODE_CENTER=1'b1.
  - Default WIDTH and CHANNELS.
- Sub-module pwm_cmp_ch: one per channel, generate loop.
  - Holds the active duty register and the registered compare output.
  - Inputs: cnt, boundary-apply strobe, pending duty.
- Counter, direction, pending flag and boundary logic stay in the top.

Test Plan:
- Edge mode, WIDTH=8, P=9, duties {0,3,10,255}, load, enable: period 10 cycles; ch0 always 0; ch1 high 3 of 10; ch2 and ch3 always 1; period_start every 10 cycles.
- Center mode, P=4, duty=2: cnt 0,1,2,3,4,3,2,1 repeating; pwm_out high 3 cycles centred on cnt=0; period_start every 8 cycles.
- Load duty 5 mid-period (edge, P=9, old duty 2): current period keeps 2 high cycles; the next period shows 5; pending high until the boundary cycle, then 0.
- Load asserted exactly on the boundary cycle (cnt==P) with no prior pending: the following period still uses old values; the new values appear one period later.
- Deassert enable mid-period, load new P=3, reassert: outputs 0 while disabled; pending clears immediately; resume at cnt=0 with 4-cycle period and period_start on the first cycle.
- Assert rst mid center-mode period with a pending load: next cycle cnt=0, pwm_out=0, pending=0; after release with enable=1, the all-ones period runs with duty 0, so outputs stay low.
